// File: rtl/ece423_i2c_pkg.sv
// Shared types and constants for the ECE423 byte-level I2C master.
// Holds the FSM state encoding, CMD bit positions and register addresses.
package ece423_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BIT   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int CMD_START = 0;
  localparam int CMD_WRITE = 1;
  localparam int CMD_READ  = 2;
  localparam int CMD_STOP  = 3;
  localparam int CMD_NACK  = 4;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  // Bit counter value of the 9th (ACK) bit of a byte.
  localparam logic [3:0] LAST_BIT = 4'd8;

endpackage

// File: rtl/ece423_i2c_qtick.sv
// SCL quarter-period divider: counts 0..CLK_DIV-1 while enabled and
// pulses tick_o on the last count; clr_i restarts the count at zero.
module ece423_i2c_qtick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/ece423_i2c_byte_master.sv
// Avalon-MM byte-level I2C master: CPU issues START/WRITE/READ/STOP commands,
// the block sequences open-drain SCL/SDA in quarter-period steps and reports busy/ack.
module ece423_i2c_byte_master
  import ece423_i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  state_t      state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [3:0]  bit_q, bit_d;
  logic        busy_q, busy_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rsh_q, rsh_d;
  logic        has_byte_q, has_byte_d;
  logic        rd_q, rd_d;
  logic        stop_q, stop_d;
  logic        nack_q, nack_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [1:0]  sync_q;
  logic        enter;
  logic        tick;

  // A register write is a single-cycle strobe (chipselect & ~write_n) with no
  // wait states; a CMD write is only taken when idle and some phase bit is set.
  logic wr_data, wr_cmd, accept, sda_s;
  assign wr_data = chipselect && !write_n && (address == ADDR_DATA);
  assign wr_cmd  = chipselect && !write_n && (address == ADDR_CMD);
  assign accept  = wr_cmd && !busy_q && (|writedata[3:0]);
  assign sda_s   = sync_q[1];

  logic unused_wd;
  assign unused_wd = ^writedata[31:8];

  ece423_i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (accept),
    .en_i   (busy_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    busy_d     = busy_q;
    ack_err_d  = ack_err_q;
    tx_d       = wr_data ? writedata[7:0] : tx_q;
    rx_d       = rx_q;
    sh_d       = sh_q;
    rsh_d      = rsh_q;
    has_byte_d = has_byte_q;
    rd_d       = rd_q;
    stop_d     = stop_q;
    nack_d     = nack_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    enter      = 1'b0;

    if (accept) begin
      busy_d     = 1'b1;
      ack_err_d  = 1'b0;
      sh_d       = tx_q;
      has_byte_d = writedata[CMD_WRITE] | writedata[CMD_READ];
      rd_d       = !writedata[CMD_WRITE] && writedata[CMD_READ];
      stop_d     = writedata[CMD_STOP];
      nack_d     = writedata[CMD_NACK];
      qtr_d      = 2'd0;
      bit_d      = 4'd0;
      enter      = 1'b1;
      if (writedata[CMD_START])  state_d = ST_START;
      else if (has_byte_d)       state_d = ST_BIT;
      else                       state_d = ST_STOP;
    end else if (busy_q && tick) begin
      enter = 1'b1;
      if (qtr_q != 2'd3) begin
        qtr_d = qtr_q + 2'd1;
        // SCL has been high for a full quarter when Q2 ends: sample here.
        if (state_q == ST_BIT && qtr_q == 2'd2) begin
          if (bit_q != LAST_BIT) begin
            if (rd_q) rsh_d = {rsh_q[6:0], sda_s};
          end else if (!rd_q) begin
            ack_err_d = sda_s;
          end
        end
      end else begin
        qtr_d = 2'd0;
        case (state_q)
          ST_START: state_d = has_byte_q ? ST_BIT : (stop_q ? ST_STOP : ST_IDLE);
          ST_BIT: begin
            scl_d = 1'b1;
            if (bit_q == LAST_BIT) begin
              if (rd_q) rx_d = rsh_q;
              state_d = stop_q ? ST_STOP : ST_IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
          default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
          busy_d = 1'b0;
          enter  = 1'b0;
          scl_d  = (state_q != ST_STOP);
          sda_d  = 1'b0;
        end
      end
    end

    // Line changes applied on entry to each quarter; unlisted quarters hold.
    if (enter) begin
      case (state_d)
        ST_START: begin
          case (qtr_d)
            2'd0:    sda_d = 1'b0;
            2'd1:    scl_d = 1'b0;
            2'd2:    sda_d = 1'b1;
            default: scl_d = 1'b1;
          endcase
        end
        ST_BIT: begin
          if (qtr_d == 2'd0) begin
            scl_d = 1'b1;
            sda_d = (bit_d == LAST_BIT) ? (rd_d && !nack_d) : (!rd_d && !sh_d[7]);
          end else if (qtr_d == 2'd2) begin
            scl_d = 1'b0;
          end
        end
        ST_STOP: begin
          case (qtr_d)
            2'd0:    sda_d = 1'b1;
            2'd1:    scl_d = 1'b0;
            2'd2:    sda_d = 1'b0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      qtr_q      <= 2'd0;
      bit_q      <= 4'd0;
      busy_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      tx_q       <= 8'd0;
      rx_q       <= 8'd0;
      sh_q       <= 8'd0;
      rsh_q      <= 8'd0;
      has_byte_q <= 1'b0;
      rd_q       <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
      scl_q      <= 1'b0;
      sda_q      <= 1'b0;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      ack_err_q  <= ack_err_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sh_q       <= sh_d;
      rsh_q      <= rsh_d;
      has_byte_q <= has_byte_d;
      rd_q       <= rd_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      sync_q     <= {sync_q[0], sda_in};
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA:   readdata = {24'd0, rx_q};
      ADDR_STATUS: readdata = {30'd0, ack_err_q, busy_q};
      default:     readdata = 32'd0;
    endcase
  end

  assign scl_oe = scl_q;
  assign sda_oe = sda_q;

endmodule

// File: tb/tb_ece423_i2c_byte_master.sv
// Bench for ece423_i2c_byte_master: open-drain bus, I2C slave BFM, bus monitor
// and a command-level reference model of timing, bytes on the wire and status.
module tb_ece423_i2c_byte_master;
  import ece423_i2c_pkg::*;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = ADDR_STATUS;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        sda_in;
  logic        scl_oe, sda_oe;

  always #5 clk = ~clk;

  ece423_i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe)
  );

  // Open-drain bus and slave BFM
  logic       slave_pull = 1'b0;
  logic       slave_rd = 1'b0;
  logic       slave_ack = 1'b1;
  logic [7:0] slave_byte = 8'd0;
  assign sda_in = ~(sda_oe | slave_pull);

  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  logic       scl_now, sda_now;
  int         falls = 0, mon_cnt = 0, start_seen = 0, stop_seen = 0;
  logic [8:0] mon_sh = 9'd0;
  logic [8:0] mon_q[$];
  logic [8:0] exp_q[$];

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [7:0] tx_m = 8'd0, rx_m = 8'd0;
  logic       ack_err_m = 1'b0, line_scl_m = 1'b0, line_sda_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor (start/stop/bits) and slave; slave only moves SDA while SCL is low.
  always @(negedge clk) begin
    int idx;
    scl_now = ~scl_oe;
    sda_now = ~(sda_oe | slave_pull);
    if (scl_prev && scl_now && sda_prev && !sda_now) begin
      start_seen++; falls = 0; mon_cnt = 0;
    end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
      stop_seen++; falls = 0; mon_cnt = 0;
    end
    if (!scl_prev && scl_now) begin
      mon_sh = {mon_sh[7:0], sda_now};
      mon_cnt++;
      if (mon_cnt == 9) begin
        mon_q.push_back(mon_sh);
        mon_cnt = 0;
      end
    end
    if (scl_prev && !scl_now) begin
      falls++;
      idx = 8 - falls;
      if (slave_rd) slave_pull = (falls >= 1 && falls <= 8) ? ~slave_byte[idx[2:0]] : 1'b0;
      else          slave_pull = slave_ack && (falls == 9);
    end
    scl_prev = scl_now;
    sda_prev = ~(sda_oe | slave_pull);
  end

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
    address = ADDR_STATUS;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
  endtask

  // Issues a CMD write and counts cycles with busy=1; optionally writes DATA
  // and a further CMD while busy.
  task automatic run_cmd(input logic [31:0] cmd, input bit inject, input logic [7:0] new_tx,
                         output int cyc);
    @(negedge clk);
    address = ADDR_CMD; writedata = cmd; chipselect = 1'b1; write_n = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
      #1;
      if (!readdata[0]) break;
      cyc++;
      if (inject && cyc == 10) begin
        address = ADDR_DATA; writedata = {24'd0, new_tx}; chipselect = 1'b1; write_n = 1'b0;
      end
      if (inject && cyc == 11) begin
        address = ADDR_CMD; writedata = 32'h0F; chipselect = 1'b1; write_n = 1'b0;
      end
    end
  endtask

  task automatic do_txn(input logic [31:0] cmd, input bit inject, input logic [7:0] new_tx,
                        input logic sack, input bit srd, input logic [7:0] sbyte);
    bit s, w, r, p, nk, valid;
    int cyc, exp_cyc, st0, sp0;
    logic [31:0] d;
    valid = |cmd[3:0];
    s = cmd[0]; w = cmd[1]; r = cmd[2] & ~cmd[1]; p = cmd[3]; nk = cmd[4];
    slave_rd = srd; slave_ack = sack; slave_byte = sbyte;
    mon_q.delete(); exp_q.delete();
    st0 = start_seen; sp0 = stop_seen;
    exp_cyc = 0;
    if (valid) begin
      exp_cyc = (4 * int'(s) + 36 * int'(w | r) + 4 * int'(p)) * CLK_DIV;
      if (w) exp_q.push_back({tx_m, ~sack});
      if (r) exp_q.push_back({sbyte, nk});
      ack_err_m = w ? ~sack : 1'b0;
      if (r) rx_m = sbyte;
      line_scl_m = ~p;
      line_sda_m = 1'b0;
    end
    run_cmd(cmd, inject, new_tx, cyc);
    if (inject) tx_m = new_tx;
    check_eq("busy_cycles", cyc, exp_cyc);
    check_eq("starts", start_seen - st0, (valid && s) ? 1 : 0);
    check_eq("stops", stop_seen - sp0, (valid && p) ? 1 : 0);
    check_eq("nbytes", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check_eq("wire_byte_ack", {23'd0, mon_q[i]}, {23'd0, exp_q[i]});
    check_eq("scl_oe_end", {31'd0, scl_oe}, {31'd0, line_scl_m});
    check_eq("sda_oe_end", {31'd0, sda_oe}, {31'd0, line_sda_m});
    rd_reg(ADDR_STATUS, d);
    check_eq("status", d, {30'd0, ack_err_m, 1'b0});
    if (r) begin
      rd_reg(ADDR_DATA, d);
      check_eq("rx_data", d, {24'd0, rx_m});
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] cmd;
    logic [7:0]  ntx;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("rst_status", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(ADDR_DATA, d);
    check_eq("rst_data", d, 32'd0);

    // Reset mid-byte
    wr_reg(ADDR_DATA, 32'h55);
    @(negedge clk);
    address = ADDR_CMD; writedata = 32'h0B; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
    repeat (49) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_eq("abort_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("abort_status", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tx_m = 8'd0; rx_m = 8'd0; ack_err_m = 1'b0; line_scl_m = 1'b0; line_sda_m = 1'b0;

    // tx cleared by reset, then 0xA2 with ACK, then NACK, then a clearing command
    do_txn(32'h0B, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    wr_reg(ADDR_DATA, 32'hA2); tx_m = 8'hA2;
    do_txn(32'h0B, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    do_txn(32'h0B, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    do_txn(32'h09, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);

    // START alone, then READ with NACK (no STOP), then STOP alone
    do_txn(32'h01, 1'b0, 8'd0, 1'b1, 1'b1, 8'h5C);
    do_txn(32'h14, 1'b0, 8'd0, 1'b1, 1'b1, 8'h5C);
    do_txn(32'h08, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);

    // Writes while busy
    wr_reg(ADDR_DATA, 32'h3C); tx_m = 8'h3C;
    do_txn(32'h0B, 1'b1, 8'hC3, 1'b1, 1'b0, 8'd0);
    do_txn(32'h0B, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);

    // WRITE wins over READ; NACK-only is not a command
    do_txn(32'h06, 1'b0, 8'd0, 1'b1, 1'b0, 8'hFF);
    do_txn(32'h08, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    do_txn(32'h10, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);

    // Reserved address and CMD read back zero; reserved write has no effect
    wr_reg(2'd3, 32'hFFFF_FFFF);
    rd_reg(2'd3, d);
    check_eq("addr3_rd", d, 32'd0);
    rd_reg(ADDR_CMD, d);
    check_eq("cmd_rd", d, 32'd0);
    rd_reg(ADDR_DATA, d);
    check_eq("data_after_addr3", d, {24'd0, rx_m});

    // Randomized START..STOP transactions
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        ntx = 8'($urandom_range(0, 255));
        wr_reg(ADDR_DATA, {24'($urandom), ntx});
        tx_m = ntx;
      end
      cmd = $urandom;
      cmd[0] = 1'b1;
      cmd[3] = 1'b1;
      do_txn(cmd, ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), (cmd[2] & ~cmd[1]), 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
